// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and constants for the tuning word controller
//
// Purpose: controller state encoding and config mode constants.
// Ports:   none (package).
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIXED = 2'd1,
    SWEEP = 2'd2,
    HOLD  = 2'd3
  } tw_state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SWEEP = 1'b1;

endpackage

// File: rtl/tuning_word_ctrl_adder.sv
// rtl/tuning_word_ctrl_adder.sv - combinational unsigned adder
//
// Purpose: plain W-bit unsigned adder; callers widen operands to keep the carry.
// Ports:   a_i, b_i - operands (W bits)
//          sum_o    - a_i + b_i (W bits, modulo 2**W)
module tuning_word_ctrl_adder #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/tuning_word_ctrl.sv
// rtl/tuning_word_ctrl.sv - tuning word generator with shadowed config and saturating sweep
//
// Purpose: holds one pending config in a shadow buffer and applies it on a
//          sample tick; produces either a fixed tuning word or an upward sweep
//          that saturates at the stop word.
// Ports:   clk, rst_n          - clock, async active-low reset
//          enable, sample_en   - tick = sample_en && enable
//          cfg_valid/cfg_ready - config handshake (cfg_ready = shadow empty)
//          cfg_mode, cfg_start, cfg_stop, cfg_step - config payload
//          tw_out, tw_valid    - applied tuning word and its qualifier
//          sweep_done          - one-cycle pulse when a sweep saturates
module tuning_word_ctrl
  import synth_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  sample_en,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_start,
  input  logic [DATA_WIDTH-1:0] cfg_stop,
  input  logic [DATA_WIDTH-1:0] cfg_step,
  output logic [DATA_WIDTH-1:0] tw_out,
  output logic                  tw_valid,
  output logic                  sweep_done
);

  tw_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] tw_q, tw_d;
  logic                  tw_valid_q, tw_valid_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] stop_q, stop_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;

  logic                  sh_vld_q, sh_vld_d;
  logic                  sh_mode_q, sh_mode_d;
  logic [DATA_WIDTH-1:0] sh_start_q, sh_start_d;
  logic [DATA_WIDTH-1:0] sh_stop_q, sh_stop_d;
  logic [DATA_WIDTH-1:0] sh_step_q, sh_step_d;

  logic                  accept;
  logic                  tick;
  logic [DATA_WIDTH:0]   sum;

  assign accept = cfg_valid && !sh_vld_q;
  assign tick   = sample_en && enable;

  // One extra bit keeps the carry so an overshoot past the top of the range
  // is seen as >= stop instead of wrapping to a small word.
  tuning_word_ctrl_adder #(
    .W (DATA_WIDTH + 1)
  ) u_adder (
    .a_i   ({1'b0, tw_q}),
    .b_i   ({1'b0, step_q}),
    .sum_o (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tw_q       <= '0;
      tw_valid_q <= 1'b0;
      done_q     <= 1'b0;
      stop_q     <= '0;
      step_q     <= '0;
      sh_vld_q   <= 1'b0;
      sh_mode_q  <= MODE_FIXED;
      sh_start_q <= '0;
      sh_stop_q  <= '0;
      sh_step_q  <= '0;
    end else begin
      state_q    <= state_d;
      tw_q       <= tw_d;
      tw_valid_q <= tw_valid_d;
      done_q     <= done_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      sh_vld_q   <= sh_vld_d;
      sh_mode_q  <= sh_mode_d;
      sh_start_q <= sh_start_d;
      sh_stop_q  <= sh_stop_d;
      sh_step_q  <= sh_step_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tw_d       = tw_q;
    tw_valid_d = tw_valid_q;
    done_d     = 1'b0;
    stop_d     = stop_q;
    step_d     = step_q;
    sh_vld_d   = sh_vld_q;
    sh_mode_d  = sh_mode_q;
    sh_start_d = sh_start_q;
    sh_stop_d  = sh_stop_q;
    sh_step_d  = sh_step_q;

    // Acceptance only happens into an empty shadow, so a config taken on a
    // tick edge is never the one applied on that same edge.
    if (accept) begin
      sh_vld_d   = 1'b1;
      sh_mode_d  = cfg_mode;
      sh_start_d = cfg_start;
      sh_stop_d  = cfg_stop;
      sh_step_d  = cfg_step;
    end

    if (tick) begin
      if (sh_vld_q) begin
        // A pending config wins over sweep progress from any state.
        sh_vld_d   = 1'b0;
        tw_valid_d = 1'b1;
        stop_d     = sh_stop_q;
        step_d     = sh_step_q;
        if (sh_mode_q == MODE_FIXED || sh_step_q == '0) begin
          state_d = FIXED;
          tw_d    = sh_start_q;
        end else if (sh_start_q >= sh_stop_q) begin
          state_d = HOLD;
          tw_d    = sh_stop_q;
          done_d  = 1'b1;
        end else begin
          state_d = SWEEP;
          tw_d    = sh_start_q;
        end
      end else begin
        unique case (state_q)
          SWEEP: begin
            if (sum >= {1'b0, stop_q}) begin
              state_d = HOLD;
              tw_d    = stop_q;
              done_d  = 1'b1;
            end else begin
              tw_d = sum[DATA_WIDTH-1:0];
            end
          end
          IDLE, FIXED, HOLD: begin
            state_d = state_q;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  assign cfg_ready  = ~sh_vld_q;
  assign tw_out     = tw_q;
  assign tw_valid   = tw_valid_q;
  assign sweep_done = done_q;

endmodule
